// File: rtl/ts4231_pkg.sv
// Shared TS4231 definitions: configuration word, phase timing default, sequencer
// states and the pad drive pattern associated with each state.
package ts4231_pkg;

  localparam int          TS4231_CFG_BITS    = 15;
  localparam logic [14:0] TS4231_CFG_WORD    = 15'h392B;
  localparam int          TS4231_HALF_PERIOD = 48;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_START_D,
    ST_START_E,
    ST_W_DATA,
    ST_W_EHI,
    ST_W_ELO,
    ST_STOP_E,
    ST_STOP_D,
    ST_R_ELO,
    ST_R_EHI,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic d_out;
    logic d_oe;
    logic e_out;
    logic e_oe;
    logic busy;
  } pad_drv_t;

  // Pad levels held for the whole of a state; d_bit is the word bit for write states.
  function automatic pad_drv_t state_drive(input state_t s, input logic d_bit);
    pad_drv_t p;
    p = '0;
    case (s)
      ST_ARM:     p = '{d_out: 1'b1,  d_oe: 1'b1, e_out: 1'b1, e_oe: 1'b1, busy: 1'b1};
      ST_START_D: p = '{d_out: 1'b0,  d_oe: 1'b1, e_out: 1'b1, e_oe: 1'b1, busy: 1'b1};
      ST_START_E: p = '{d_out: 1'b0,  d_oe: 1'b1, e_out: 1'b0, e_oe: 1'b1, busy: 1'b1};
      ST_W_DATA:  p = '{d_out: d_bit, d_oe: 1'b1, e_out: 1'b0, e_oe: 1'b1, busy: 1'b1};
      ST_W_EHI:   p = '{d_out: d_bit, d_oe: 1'b1, e_out: 1'b1, e_oe: 1'b1, busy: 1'b1};
      ST_W_ELO:   p = '{d_out: d_bit, d_oe: 1'b1, e_out: 1'b0, e_oe: 1'b1, busy: 1'b1};
      ST_STOP_E:  p = '{d_out: 1'b0,  d_oe: 1'b1, e_out: 1'b1, e_oe: 1'b1, busy: 1'b1};
      ST_STOP_D:  p = '{d_out: 1'b1,  d_oe: 1'b1, e_out: 1'b1, e_oe: 1'b1, busy: 1'b1};
      ST_R_ELO:   p = '{d_out: 1'b0,  d_oe: 1'b0, e_out: 1'b0, e_oe: 1'b1, busy: 1'b1};
      ST_R_EHI:   p = '{d_out: 1'b0,  d_oe: 1'b0, e_out: 1'b1, e_oe: 1'b1, busy: 1'b1};
      default:    p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ts4231_config_writer_if.sv
// Control and pad bundle between the TS4231 config writer and its host/pad ring.
interface ts4231_config_writer_if #(
  parameter int N_SENSORS = 3
);
  logic                 start;
  logic [N_SENSORS-1:0] d_in;
  logic                 d_out;
  logic                 d_oe;
  logic                 e_out;
  logic                 e_oe;
  logic                 busy;
  logic                 done;
  logic [N_SENSORS-1:0] cfg_ok;

  modport master (
    output start, d_in,
    input  d_out, d_oe, e_out, e_oe, busy, done, cfg_ok
  );

  modport slave (
    input  start, d_in,
    output d_out, d_oe, e_out, e_oe, busy, done, cfg_ok
  );
endinterface

// File: rtl/ts4231_phase_timer.sv
// Reloadable down-counter; o_tick is high while the count sits at zero.
module ts4231_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tick
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_count <= '0;
    else if (i_load)           r_count <= i_load_val;
    else if (r_count != '0)    r_count <= r_count - 1'b1;
  end

  assign o_tick = (r_count == '0);
endmodule

// File: rtl/ts4231_config_writer.sv
// Bit-bangs the TS4231 config word onto the shared D/E pads, then reads it back
// from every face and reports a per-sensor match.
//   state   | meaning
//   IDLE    | pads released, waiting for start
//   ARM     | D=1 E=1 preamble
//   START_* | start condition: D falls, then E falls
//   W_*     | per bit: present D, raise E, lower E
//   STOP_*  | stop condition: E rises, then D rises
//   R_*     | D released; sensors drive D while E is high
//   FIN     | one-cycle done pulse, cfg_ok updated
module ts4231_config_writer
  import ts4231_pkg::*;
#(
  parameter int                  N_SENSORS   = 3,
  parameter int                  CFG_BITS    = TS4231_CFG_BITS,
  parameter logic [CFG_BITS-1:0] CFG_WORD    = TS4231_CFG_WORD,
  parameter int                  HALF_PERIOD = TS4231_HALF_PERIOD
) (
  input  logic                   clk_96MHz,
  input  logic                   reset_n,
  ts4231_config_writer_if.slave  bus
);
  localparam logic [3:0] BIT_MAX = 4'(CFG_BITS - 1);
  localparam logic [7:0] HP_LOAD = 8'(HALF_PERIOD - 1);

  state_t               r_state;
  logic [3:0]           r_bit;
  pad_drv_t             r_drv;
  logic                 r_done;
  logic [N_SENSORS-1:0] r_cfg_ok;
  logic [CFG_BITS-1:0]  r_shreg [N_SENSORS];

  state_t               w_next;
  logic [3:0]           w_bit_next;
  logic                 w_adv;
  logic                 w_tick;
  logic [CFG_BITS-1:0]  w_shift [N_SENSORS];

  ts4231_phase_timer #(.W(8)) u_timer (
    .clk        (clk_96MHz),
    .rst_n      (reset_n),
    .i_load     (w_adv),
    .i_load_val (HP_LOAD),
    .o_tick     (w_tick)
  );

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_shift
    assign w_shift[g] = {r_shreg[g][CFG_BITS-2:0], bus.d_in[g]};
  end

  always_comb begin
    w_next     = r_state;
    w_bit_next = r_bit;
    w_adv      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next     = ST_ARM;
          w_bit_next = BIT_MAX;
          w_adv      = 1'b1;
        end
      end
      ST_FIN: begin
        w_next = ST_IDLE;
        w_adv  = 1'b1;
      end
      default: begin
        // every timed state advances only on the last clock of its phase
        w_adv = w_tick;
        case (r_state)
          ST_ARM:     w_next = ST_START_D;
          ST_START_D: w_next = ST_START_E;
          ST_START_E: w_next = ST_W_DATA;
          ST_W_DATA:  w_next = ST_W_EHI;
          ST_W_EHI:   w_next = ST_W_ELO;
          ST_W_ELO: begin
            if (r_bit == '0) w_next = ST_STOP_E;
            else begin
              w_next     = ST_W_DATA;
              w_bit_next = r_bit - 4'd1;
            end
          end
          ST_STOP_E:  w_next = ST_STOP_D;
          ST_STOP_D: begin
            w_next     = ST_R_ELO;
            w_bit_next = BIT_MAX;
          end
          ST_R_ELO:   w_next = ST_R_EHI;
          ST_R_EHI: begin
            if (r_bit == '0) w_next = ST_FIN;
            else begin
              w_next     = ST_R_ELO;
              w_bit_next = r_bit - 4'd1;
            end
          end
          default:    w_next = ST_IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_bit    <= '0;
      r_drv    <= '0;
      r_done   <= 1'b0;
      r_cfg_ok <= '0;
      for (int i = 0; i < N_SENSORS; i++) r_shreg[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_adv) begin
        r_state <= w_next;
        r_bit   <= w_bit_next;
        r_drv   <= state_drive(w_next, CFG_WORD[w_bit_next]);
      end
      if (r_state == ST_IDLE && bus.start) begin
        r_cfg_ok <= '0;
        for (int i = 0; i < N_SENSORS; i++) r_shreg[i] <= '0;
      end
      if (r_state == ST_R_EHI && w_tick) begin
        for (int i = 0; i < N_SENSORS; i++) r_shreg[i] <= w_shift[i];
      end
      // compare against the shift value that includes the final sample
      if (w_adv && w_next == ST_FIN) begin
        r_done <= 1'b1;
        for (int i = 0; i < N_SENSORS; i++) r_cfg_ok[i] <= (w_shift[i] == CFG_WORD);
      end
    end
  end

  assign bus.d_out  = r_drv.d_out;
  assign bus.d_oe   = r_drv.d_oe;
  assign bus.e_out  = r_drv.e_out;
  assign bus.e_oe   = r_drv.e_oe;
  assign bus.busy   = r_drv.busy;
  assign bus.done   = r_done;
  assign bus.cfg_ok = r_cfg_ok;
endmodule

// File: tb/tb_ts4231_config_writer.sv
// Bench for ts4231_config_writer: phase-level pad model, echoing sensor models,
// table vectors, random readback words and hand-written corner sequences.
module tb_ts4231_config_writer;
  localparam int          HP   = 4;
  localparam int          NS   = 3;
  localparam int          SEQ  = 80 * HP;
  localparam logic [14:0] WORD = 15'h392B;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ts4231_config_writer_if #(.N_SENSORS(NS)) bus ();

  ts4231_config_writer #(.N_SENSORS(NS), .HALF_PERIOD(HP)) dut (
    .clk_96MHz (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {d_out,d_oe,e_out,e_oe,busy} for protocol phase ph (0 = ARM).
  function automatic logic [4:0] exp_pads(input int ph);
    logic [14:0] w;
    int j;
    w = WORD;
    if (ph == 0)  return 5'b11111;
    if (ph == 1)  return 5'b01111;
    if (ph == 2)  return 5'b01011;
    if (ph <= 47) begin
      j = ph - 3;
      return {w[14 - j / 3], 1'b1, (j % 3 == 1), 1'b1, 1'b1};
    end
    if (ph == 48) return 5'b01111;
    if (ph == 49) return 5'b11111;
    if (ph <= 79) return {1'b0, 1'b0, ((ph - 50) % 2 == 1), 1'b1, 1'b1};
    return 5'b00000;
  endfunction

  // Sensor models: record write bits at each driven E rise, answer reads with rb_word.
  logic [14:0]   rb_word [NS];
  logic [NS-1:0] sens_d  = '0;
  logic [16:0]   wr_shift = '0;
  logic          e_prev   = 1'b0;
  int            rd_idx   = 0;
  assign bus.d_in = sens_d;

  always @(negedge clk) begin
    if (bus.e_out && !e_prev) begin
      if (bus.d_oe) begin
        wr_shift = {wr_shift[15:0], bus.d_out};
        rd_idx   = 0;
      end else if (rd_idx < 15) begin
        for (int i = 0; i < NS; i++) sens_d[i] = rb_word[i][14 - rd_idx];
        rd_idx++;
      end
    end else if (!bus.e_out && e_prev) begin
      sens_d = NS'($urandom);
    end
    e_prev = bus.e_out;
  end

  task automatic run_seq(input logic [2:0] exp_ok, input int spur_a, input int spur_b,
                         input int tail, input string tag);
    int         done_m   = -1;
    int         done_n   = 0;
    int         pad_err  = 0;
    int         first_bad = -1;
    logic [4:0] got;
    logic [4:0] want;
    @(negedge clk);
    bus.start = 1'b1;
    for (int m = 1; m <= SEQ + 1 + tail; m++) begin
      @(negedge clk);
      bus.start = (m == spur_a || m == spur_b);
      if (m == 1) chk({tag, "_cfg_ok_clear"}, 32'(bus.cfg_ok), 32'd0);
      got  = {bus.d_out, bus.d_oe, bus.e_out, bus.e_oe, bus.busy};
      want = (m <= SEQ) ? exp_pads((m - 1) / HP) : 5'b00000;
      if (got !== want) begin
        pad_err++;
        if (first_bad < 0) first_bad = m;
      end
      if (bus.done === 1'b1) begin
        done_n++;
        if (done_m < 0) done_m = m;
      end else if (bus.done !== 1'b0) begin
        pad_err++;
      end
    end
    bus.start = 1'b0;
    chk($sformatf("%s_pads first_bad_cycle=%0d", tag, first_bad), 32'(pad_err), 32'd0);
    chk({tag, "_done_cycle"}, 32'(done_m), 32'(SEQ + 1));
    chk({tag, "_done_count"}, 32'(done_n), 32'd1);
    chk({tag, "_cfg_ok"}, 32'(bus.cfg_ok), 32'(exp_ok));
    chk({tag, "_write_bits"}, 32'(wr_shift[15:1]), 32'(WORD));
  endtask

  task automatic set_rb(input logic [2:0][14:0] rb);
    for (int i = 0; i < NS; i++) rb_word[i] = rb[i];
  endtask

  typedef struct packed {
    logic [2:0][14:0] rb;
    logic [2:0]       ok;
  } vec_t;

  vec_t vecs [5];
  logic [2:0][14:0] rrb;
  logic [2:0]       rok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rb: {15'h392B, 15'h392B, 15'h392B}, ok: 3'b111};
    vecs[1] = '{rb: {15'h392B, 15'h392A, 15'h392B}, ok: 3'b101};
    vecs[2] = '{rb: {15'h0000, 15'h0000, 15'h0000}, ok: 3'b000};
    vecs[3] = '{rb: {15'h392B, 15'h392B, 15'h792B}, ok: 3'b110};
    vecs[4] = '{rb: {15'h7FFF, 15'h392B, 15'h392B}, ok: 3'b011};

    bus.start = 1'b0;
    for (int i = 0; i < NS; i++) rb_word[i] = WORD;

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        32'({bus.d_out, bus.d_oe, bus.e_out, bus.e_oe, bus.busy, bus.done, bus.cfg_ok}), 32'd0);

    for (int v = 0; v < 5; v++) begin
      set_rb(vecs[v].rb);
      run_seq(vecs[v].ok, 0, 0, 5, $sformatf("vec%0d", v));
    end

    set_rb({WORD, WORD, WORD});
    run_seq(3'b111, 10, 200, 10, "start_busy");
    run_seq(3'b111, SEQ + 1, 0, 10, "start_in_fin");

    run_seq(3'b111, 0, 0, 0, "b2b_first");
    set_rb({WORD, 15'h392A, WORD});
    run_seq(3'b101, 0, 0, 5, "b2b_second");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NS; i++) begin
        rrb[i] = ($urandom_range(1, 0) == 1) ? WORD : (WORD ^ (15'(1) << $urandom_range(14, 0)));
        rok[i] = (rrb[i] == WORD);
      end
      set_rb(rrb);
      repeat ($urandom_range(5, 0)) @(negedge clk);
      run_seq(rok, $urandom_range(SEQ, 2), 0, 3, $sformatf("rand%0d", r));
    end

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_reset_w_ehi", 32'({bus.d_oe, bus.e_oe, bus.e_out}), 32'b111);
    rst_n = 1'b0;
    #1;
    chk("async_reset_release",
        32'({bus.d_out, bus.d_oe, bus.e_out, bus.e_oe, bus.busy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle",
        32'({bus.d_out, bus.d_oe, bus.e_out, bus.e_oe, bus.busy, bus.done, bus.cfg_ok}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
